// File: rtl/cc1200_spi_pkg.sv
// cc1200_spi_pkg
//   Shared definitions for the CC1200 SPI register-interface model.
//   Header byte layout {R/W, BURST, ADDR[5:0]}, the default strobe base
//   address, FSM state encoding and the status-byte builder.
package cc1200_spi_pkg;

  localparam int unsigned RW_BIT    = 7;
  localparam int unsigned BURST_BIT = 6;
  localparam int unsigned ADDR_MSB  = 5;

  localparam logic [5:0] STROBE_BASE_DEFAULT = 6'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    IGN  = 2'd3
  } spi_state_e;

  // Status byte shifted out during the header: {CHIP_RDYn, STATE[2:0], 4'b0000}
  function automatic logic [7:0] status_byte(input logic       rdy_n,
                                             input logic [2:0] state);
    return {rdy_n, state, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
//   Multi-flop synchronizer for one asynchronous pin, followed by a
//   single-cycle edge detector.
//   Ports:
//     clk, rst  - system clock, synchronous active-high reset
//     pin_i     - asynchronous pin
//     level_o   - synchronized pin level
//     rise_o    - 1-clk pulse on a synchronized 0->1 transition
//     fall_o    - 1-clk pulse on a synchronized 1->0 transition
//   STAGES must be at least 2.
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Clearing to 0 means a pin held low across reset (CS_n mid-transaction)
  // produces no fall, so a transaction cut by reset is not resumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cc1200_spi_responder.sv
// cc1200_spi_responder
//   SPI mode-0 slave modelling the CC1200 register interface. Decodes the
//   header byte, serves single/burst register reads and writes and command
//   strobes, and returns the status byte on MISO during the header.
//   Ports:
//     clk, rst                 - system clock, synchronous active-high reset
//     sclk_i, mosi_i, cs_n_i   - asynchronous SPI pins
//     miso_o, miso_oe          - SPI data out and its drive enable
//     chip_rdy_n, status_state - live status bits sampled at CS_n fall
//     reg_wr_en/addr/data      - 1-clk pulse per committed register write
//     strobe_valid/addr        - 1-clk pulse per strobe header
//     busy                     - transaction in progress
module cc1200_spi_responder
  import cc1200_spi_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 48,
  parameter logic [5:0]  STROBE_BASE = STROBE_BASE_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic       miso_o,
  output logic       miso_oe,
  input  logic       chip_rdy_n,
  input  logic [2:0] status_state,
  output logic       reg_wr_en,
  output logic [5:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       strobe_valid,
  output logic [5:0] strobe_addr,
  output logic       busy
);

  localparam logic [5:0] LAST_ADDR = 6'(NUM_REGS - 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin_i(sclk_i),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .pin_i(cs_n_i),
    .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] in_sh_q;
  logic [7:0] out_sh_q;
  logic [7:0] stat_q;
  logic       rw_q, burst_q;
  logic [5:0] addr_q;
  logic       miso_q, miso_oe_q;
  logic       wr_en_q, stb_q;
  logic [5:0] wr_addr_q, stb_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [NUM_REGS];

  logic [7:0] in_byte, stat_now, rd_hdr, rd_nxt;
  logic [5:0] hdr_addr, addr_nxt;

  always_comb begin
    in_byte  = {in_sh_q, mosi_lvl};
    stat_now = status_byte(chip_rdy_n, status_state);
    hdr_addr = in_byte[ADDR_MSB:0];
    addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + 6'd1;
    rd_hdr   = (hdr_addr <= LAST_ADDR) ? regs_q[hdr_addr] : '0;
    rd_nxt   = (addr_nxt <= LAST_ADDR) ? regs_q[addr_nxt] : '0;
  end

  // CS rise outranks CS fall, which outranks any SCLK edge on the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      in_sh_q    <= '0;
      out_sh_q   <= '0;
      stat_q     <= '0;
      rw_q       <= 1'b0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      stb_q      <= 1'b0;
      stb_addr_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      wr_en_q <= 1'b0;
      stb_q   <= 1'b0;
      if (cs_rise) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else if (cs_fall) begin
        state_q   <= HDR;
        bit_cnt_q <= '0;
        stat_q    <= stat_now;
        miso_q    <= stat_now[7];
        out_sh_q  <= {stat_now[6:0], 1'b0};
        miso_oe_q <= 1'b1;
      end else if (state_q != IDLE) begin
        if (sclk_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          in_sh_q   <= in_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              HDR: begin
                rw_q    <= in_byte[RW_BIT];
                burst_q <= in_byte[BURST_BIT];
                addr_q  <= hdr_addr;
                if (hdr_addr >= STROBE_BASE) begin
                  stb_q      <= 1'b1;
                  stb_addr_q <= hdr_addr;
                  state_q    <= IGN;
                  out_sh_q   <= stat_q;
                end else begin
                  state_q  <= DATA;
                  out_sh_q <= in_byte[RW_BIT] ? rd_hdr : stat_q;
                end
              end
              DATA: begin
                if (!rw_q) begin
                  if (addr_q <= LAST_ADDR) regs_q[addr_q] <= in_byte;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= in_byte;
                end
                if (burst_q) begin
                  addr_q   <= addr_nxt;
                  out_sh_q <= rw_q ? rd_nxt : stat_q;
                end else begin
                  state_q  <= IGN;
                  out_sh_q <= stat_q;
                end
              end
              default: out_sh_q <= stat_q;
            endcase
          end
        end else if (sclk_fall) begin
          miso_q   <= out_sh_q[7];
          out_sh_q <= {out_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  assign miso_o       = miso_q;
  assign miso_oe      = miso_oe_q;
  assign reg_wr_en    = wr_en_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign strobe_valid = stb_q;
  assign strobe_addr  = stb_addr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// tb_cc1200_spi_responder
//   Directed bench for cc1200_spi_responder: a bit-banged SPI mode-0 master
//   with hand-computed expected MISO bytes and write/strobe pulse logs.
module tb_cc1200_spi_responder;

  localparam int HALF = 8;  // clk cycles per SCLK phase

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       chip_rdy_n = 1'b0;
  logic [2:0] status_state = 3'b010;
  logic       miso_o, miso_oe, reg_wr_en, strobe_valid, busy;
  logic [5:0] reg_wr_addr, strobe_addr;
  logic [7:0] reg_wr_data;

  cc1200_spi_responder #(
    .NUM_REGS(48),
    .STROBE_BASE(6'h30),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk_i(sclk),
    .mosi_i(mosi),
    .cs_n_i(cs_n),
    .miso_o(miso_o),
    .miso_oe(miso_oe),
    .chip_rdy_n(chip_rdy_n),
    .status_state(status_state),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .strobe_valid(strobe_valid),
    .strobe_addr(strobe_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  int unsigned wr_cnt  = 0;
  int unsigned stb_cnt = 0;
  logic [5:0]  wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  logic [5:0]  last_stb_addr = '0;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr_log.push_back(reg_wr_addr);
      wr_data_log.push_back(reg_wr_data);
    end
    if (strobe_valid) begin
      stb_cnt++;
      last_stb_addr = strobe_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nb bits of tx (MSB first); rx holds MISO as seen just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx[i] = miso_o;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    int unsigned w0, s0;

    // Reset state
    wait_clk(4);
    check("rst_miso", miso_o, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_strobe", strobe_valid, 0);
    rst = 1'b0;
    wait_clk(4);

    // Single write 0x05 <= 0xA5
    w0 = wr_cnt;
    cs_begin();
    check("wr_oe", miso_oe, 1);
    check("wr_busy", busy, 1);
    spi_bits(8'h05, 8, rx); check("wr_stat", rx, 8'h20);
    spi_bits(8'hA5, 8, rx); check("wr_stat2", rx, 8'h20);
    cs_end();
    check("wr_cnt", wr_cnt - w0, 1);
    check("wr_addr", wr_addr_log[w0], 6'h05);
    check("wr_data", wr_data_log[w0], 8'hA5);
    check("wr_busy_end", busy, 0);
    check("wr_oe_end", miso_oe, 0);
    check("wr_miso_end", miso_o, 0);

    // Single read 0x05
    w0 = wr_cnt;
    cs_begin();
    spi_bits(8'h85, 8, rx); check("rd_stat", rx, 8'h20);
    spi_bits(8'h00, 8, rx); check("rd_data", rx, 8'hA5);
    cs_end();
    check("rd_no_wr", wr_cnt - w0, 0);

    // Burst write with wrap from 0x2E
    w0 = wr_cnt;
    cs_begin();
    spi_bits(8'h6E, 8, rx); check("bw_stat0", rx, 8'h20);
    spi_bits(8'h11, 8, rx); check("bw_stat1", rx, 8'h20);
    spi_bits(8'h22, 8, rx); check("bw_stat2", rx, 8'h20);
    spi_bits(8'h33, 8, rx); check("bw_stat3", rx, 8'h20);
    cs_end();
    check("bw_cnt", wr_cnt - w0, 3);
    check("bw_a0", wr_addr_log[w0],     6'h2E);
    check("bw_d0", wr_data_log[w0],     8'h11);
    check("bw_a1", wr_addr_log[w0 + 1], 6'h2F);
    check("bw_d1", wr_data_log[w0 + 1], 8'h22);
    check("bw_a2", wr_addr_log[w0 + 2], 6'h00);
    check("bw_d2", wr_data_log[w0 + 2], 8'h33);

    // Burst read with wrap from 0x2E
    cs_begin();
    spi_bits(8'hEE, 8, rx); check("br_stat", rx, 8'h20);
    spi_bits(8'h00, 8, rx); check("br_d0", rx, 8'h11);
    spi_bits(8'h00, 8, rx); check("br_d1", rx, 8'h22);
    spi_bits(8'h00, 8, rx); check("br_d2", rx, 8'h33);
    cs_end();

    // Strobe 0x36 with a different status byte (0xF0)
    chip_rdy_n   = 1'b1;
    status_state = 3'b111;
    w0 = wr_cnt;
    s0 = stb_cnt;
    cs_begin();
    spi_bits(8'h36, 8, rx); check("stb_stat0", rx, 8'hF0);
    spi_bits(8'hFF, 8, rx); check("stb_stat1", rx, 8'hF0);
    cs_end();
    check("stb_cnt", stb_cnt - s0, 1);
    check("stb_addr", last_stb_addr, 6'h36);
    check("stb_no_wr", wr_cnt - w0, 0);
    chip_rdy_n   = 1'b0;
    status_state = 3'b010;

    // Abort: write header 0x07 plus 4 data bits, then CS_n high
    w0 = wr_cnt;
    cs_begin();
    spi_bits(8'h07, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs_end();
    check("ab_no_wr", wr_cnt - w0, 0);
    check("ab_oe", miso_oe, 0);
    check("ab_busy", busy, 0);
    cs_begin();
    spi_bits(8'h87, 8, rx);
    spi_bits(8'h00, 8, rx); check("ab_reg7", rx, 8'h00);
    cs_end();
    w0 = wr_cnt;
    cs_begin();
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h5A, 8, rx);
    cs_end();
    check("ab_wr_cnt", wr_cnt - w0, 1);
    check("ab_wr_addr", wr_addr_log[w0], 6'h07);
    cs_begin();
    spi_bits(8'h87, 8, rx);
    spi_bits(8'h00, 8, rx); check("ab_rdback", rx, 8'h5A);
    cs_end();

    // Reset in the middle of a burst read (after 12 bits)
    cs_begin();
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'h00, 4, rx);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(1);
    check("mr_oe", miso_oe, 0);
    check("mr_busy", busy, 0);
    check("mr_miso", miso_o, 0);
    spi_bits(8'h00, 4, rx);
    check("mr_busy_ign", busy, 0);
    check("mr_oe_ign", miso_oe, 0);
    cs_end();
    cs_begin();
    spi_bits(8'hC0, 8, rx); check("mr_stat", rx, 8'h20);
    for (int i = 0; i < 48; i++) begin
      spi_bits(8'h00, 8, rx);
      check($sformatf("mr_clr%0d", i), rx, 8'h00);
    end
    cs_end();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
